// File: rtl/square_move_collector.sv
// Snapshots the sixteen direction move words of one square and serializes the valid ones over valid/ready.
// Optional define SQUARE_MOVE_COLLECTOR_DIR_EN adds the out_dir direction-index output.
module square_move_collector #(
   parameter int WORD_W    = 32,
   parameter int VALID_BIT = 31
) (
   input  logic              clk,
   input  logic              clear_n,
   input  logic              start,
   input  logic [WORD_W-1:0] U_move_in,
   input  logic [WORD_W-1:0] D_move_in,
   input  logic [WORD_W-1:0] L_move_in,
   input  logic [WORD_W-1:0] R_move_in,
   input  logic [WORD_W-1:0] UL_move_in,
   input  logic [WORD_W-1:0] UR_move_in,
   input  logic [WORD_W-1:0] DL_move_in,
   input  logic [WORD_W-1:0] DR_move_in,
   input  logic [WORD_W-1:0] UUL_move_in,
   input  logic [WORD_W-1:0] UUR_move_in,
   input  logic [WORD_W-1:0] LLU_move_in,
   input  logic [WORD_W-1:0] RRU_move_in,
   input  logic [WORD_W-1:0] DDL_move_in,
   input  logic [WORD_W-1:0] DDR_move_in,
   input  logic [WORD_W-1:0] LLD_move_in,
   input  logic [WORD_W-1:0] RRD_move_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_move,
   output logic              busy,
   output logic              done,
   output logic [4:0]        move_count
`ifdef SQUARE_MOVE_COLLECTOR_DIR_EN
   ,
   output logic [3:0]        out_dir
`endif
);

   typedef enum logic [1:0] {IDLE, DRAIN, FINISH} state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] in_words [16];
   logic [WORD_W-1:0] snap_q   [16];
   logic [15:0]       pending_q, pending_d, vbits;
   logic [4:0]        count_q, count_d, move_count_d;
   logic              load, valid_d, done_d;
   logic [3:0]        idx_d;
   logic [WORD_W-1:0] move_d;

   function automatic logic [3:0] lowest(input logic [15:0] v);
      lowest = 4'd0;
      for (int i = 15; i >= 0; i--)
         if (v[i]) lowest = 4'(i);
   endfunction

   assign in_words[0]  = U_move_in;
   assign in_words[1]  = D_move_in;
   assign in_words[2]  = L_move_in;
   assign in_words[3]  = R_move_in;
   assign in_words[4]  = UL_move_in;
   assign in_words[5]  = UR_move_in;
   assign in_words[6]  = DL_move_in;
   assign in_words[7]  = DR_move_in;
   assign in_words[8]  = UUL_move_in;
   assign in_words[9]  = UUR_move_in;
   assign in_words[10] = LLU_move_in;
   assign in_words[11] = RRU_move_in;
   assign in_words[12] = DDL_move_in;
   assign in_words[13] = DDR_move_in;
   assign in_words[14] = LLD_move_in;
   assign in_words[15] = RRD_move_in;

   assign load = (state_q == IDLE) && start;

   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      count_d      = count_q;
      move_count_d = move_count;
      done_d       = 1'b0;
      vbits        = '0;
      for (int i = 0; i < 16; i++) vbits[i] = in_words[i][VALID_BIT];
      case (state_q)
         IDLE: begin
            if (start) begin
               pending_d = vbits;
               count_d   = 5'd0;
               state_d   = DRAIN;
            end
         end
         DRAIN: begin
            // The presented word is always the lowest pending bit, so a transfer clears that bit
            if (out_valid && out_ready) begin
               pending_d = pending_q & (pending_q - 16'd1);
               count_d   = count_q + 5'd1;
            end
            if (pending_d == 16'd0) begin
               state_d      = FINISH;
               done_d       = 1'b1;
               move_count_d = count_d;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      valid_d = (state_d == DRAIN) && (pending_d != 16'd0);
      idx_d   = lowest(pending_d);
      // Word source bypasses the snapshot on the load cycle so the first move appears right after start
      move_d  = out_move;
      if (valid_d) move_d = load ? in_words[idx_d] : snap_q[idx_d];
   end

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         count_q    <= '0;
         out_valid  <= 1'b0;
         out_move   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         move_count <= '0;
         for (int i = 0; i < 16; i++) snap_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         count_q    <= count_d;
         out_valid  <= valid_d;
         out_move   <= move_d;
         busy       <= (state_d != IDLE);
         done       <= done_d;
         move_count <= move_count_d;
         if (load)
            for (int i = 0; i < 16; i++) snap_q[i] <= in_words[i];
      end
   end

`ifdef SQUARE_MOVE_COLLECTOR_DIR_EN
   always_ff @(posedge clk) begin
      if (!clear_n)     out_dir <= 4'd0;
      else if (valid_d) out_dir <= idx_d;
   end
`endif

endmodule

// File: doc/square_move_collector.md
# square_move_collector

Drains the sixteen 32-bit per-direction move words produced by one `square` cell (eight ray directions plus eight knight directions) into a single serialized move stream. On a start pulse it snapshots all sixteen words, then emits each valid word one at a time over a valid/ready handshake in a fixed direction order. When the list is drained it pulses `done` and reports the move count. It sits between the square array and the downstream move list / search FIFO, one instance per scanned square.

## Interface
- `WORD_W`, 32, width of every move word.
- `VALID_BIT`, 31, bit index inside a move word that flags it as a legal move; the other bits are opaque payload.
- `clk`  in  1  clock, all logic on its rising edge.
- `clear_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to snapshot and drain the current move words.
- `U_move_in`, `D_move_in`, `L_move_in`, `R_move_in`, `UL_move_in`, `UR_move_in`, `DL_move_in`, `DR_move_in`  in  WORD_W each  ray-direction move words; direction indices 0–7 in this order.
- `UUL_move_in`, `UUR_move_in`, `LLU_move_in`, `RRU_move_in`, `DDL_move_in`, `DDR_move_in`, `LLD_move_in`, `RRD_move_in`  in  WORD_W each  knight move words; direction indices 8–15 in this order.
- `out_valid`  out  1  `out_move` holds a valid move.
- `out_ready`  in  1  downstream accepts `out_move` this cycle.
- `out_move`  out  WORD_W  current move word, passed through unmodified.
- `busy`  out  1  a snapshot is being drained.
- `done`  out  1  one-cycle pulse when the drain completes.
- `move_count`  out  5  number of moves emitted in the last drain, 0–16.
- `out_dir`  out  4  direction index of `out_move`. This port exists only with `SQUARE_MOVE_COLLECTOR_DIR_EN`.

## Operation
- There are three states: IDLE, DRAIN and FINISH.
- **IDLE**
  - `start` registers all 16 inputs into a snapshot.
  - It also loads `pending[15:0]`, where bit i is the VALID_BIT of word i.
  - It clears the running count and moves to DRAIN.
- **DRAIN**
  - `out_move` is the snapshot word at the lowest set index of `pending`. `out_valid` is 1.
  - A transfer happens when `out_valid && out_ready`. On a transfer, that pending bit clears and the count increments.
  - The next lowest pending index is presented on the following cycle.
  - When `pending` becomes zero, the block goes to FINISH. If `pending` was zero at load, it goes to FINISH directly.
- **FINISH**
  - `done` is 1 for exactly one cycle.
  - `move_count` latches the running count and holds it until the next FINISH.
  - The block returns to IDLE.
- `busy` is 1 in DRAIN and FINISH.
- `start` is ignored unless the block is in IDLE. Input changes after the snapshot have no effect on the current drain.
- The snapshot must be stable: `out_move` does not change while `out_valid && !out_ready`.
- `out_valid` is 0 in IDLE and in FINISH.
- `clear_n` low at any clock edge, including mid-drain, forces:
  - state IDLE;
  - `pending` 0, snapshot 0;
  - `out_valid` 0, `out_move` 0;
  - `busy` 0, `done` 0, `move_count` 0, `out_dir` 0.
  - A transfer is not counted in the cycle in which `clear_n` is low.

## Timing
- All outputs are registered.
- `start` is sampled at edge N.
- If at least one word is valid, `out_valid` rises after edge N.
- With `out_ready` held high, k valid words transfer on k consecutive cycles.
- `done` is high for the cycle after the last transfer. IDLE follows one cycle later, so the earliest accepted re-`start` is sampled while `done` is high + 1 cycle.
- Zero valid words: `done` rises one cycle after the DRAIN entry cycle; `move_count` is 0.
- `out_ready` is combinationally unregistered upstream and may toggle every cycle. A low `out_ready` stalls without losing or duplicating a word.
- The count is 5 bits and cannot overflow; 16 is the maximum.

## Configuration
- `SQUARE_MOVE_COLLECTOR_DIR_EN` defined:
  - adds the `out_dir` output;
  - `out_dir` carries the direction index selected alongside `out_move`, with the same stability rule;
  - it resets to 0 and holds its last value when not valid.
- Undefined: the `out_dir` port and its register are absent; the rest of the behaviour is identical.

## Test plan
- Reset: hold `clear_n`=0 for 2 cycles with random inputs → all outputs 0 and `busy`=0.
- Sparse drain:
  - Stimulus: valid words only at U (0x8000_0011), DR (0x8000_0077) and RRD (0x8000_00FF); `out_ready`=1; pulse `start`.
  - Required: these three words appear on consecutive cycles in that order, then `done`=1 and `move_count`=3.
  - With `SQUARE_MOVE_COLLECTOR_DIR_EN`: `out_dir` reads 0, 7, 15.
- Backpressure:
  - Stimulus: all 16 words valid; `out_ready` alternates 1/0.
  - Required: each word is held stable while stalled, 16 transfers occur with no duplicates, and `move_count`=16.
- Empty:
  - Stimulus: all VALID_BITs 0 (payloads nonzero); `start`.
  - Required: `out_valid` never rises, `done` pulses once and `move_count`=0.
- Snapshot isolation and ignored start:
  - Stimulus: change all inputs and pulse `start` again mid-drain.
  - Required: the original words finish draining and the second `start` has no effect.
- Mid-drain reset:
  - Stimulus: `clear_n`=0 after 2 of 5 transfers, then a new `start`.
  - Required: the old drain is aborted, the new drain emits from index 0, and `move_count` reflects only the new drain.
